// File: rtl/liteic_pkg.sv
// Shared types for the LiteIC address router: config field selector and region attributes.
package liteic_pkg;

    typedef enum logic [1:0] {
        CFG_BASE = 2'd0,
        CFG_SIZE = 2'd1,
        CFG_ATTR = 2'd2,
        CFG_RSVD = 2'd3
    } cfg_field_e;

    typedef struct packed {
        logic wr_en;
        logic en;
    } rgn_attr_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/liteic_addr_match.sv
// Combinational region matcher: per-region window compare, lowest-index priority,
// enable and write-permission check.
module liteic_addr_match
    import liteic_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int NUM_REGIONS = 4,
    localparam int IDX_W       = idx_width(NUM_REGIONS)
) (
    input  logic [ADDR_WIDTH-1:0]  base [NUM_REGIONS],
    input  logic [ADDR_WIDTH-1:0]  size [NUM_REGIONS],
    input  rgn_attr_t              attr [NUM_REGIONS],
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic                   we,
    output logic [NUM_REGIONS-1:0] rgn,
    output logic [IDX_W-1:0]       idx,
    output logic                   err
);

    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0] sel_rgn;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_wr;
    logic                   found;

    always_comb begin
        hit = '0;
        // offset compare stays ADDR_WIDTH wide so a region ending at the top of the map never wraps
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            hit[i] = attr[i].en && (addr >= base[i]) && ((addr - base[i]) < size[i]);
        end
    end

    always_comb begin
        found   = 1'b0;
        sel_rgn = '0;
        sel_idx = '0;
        sel_wr  = 1'b0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (hit[i] && !found) begin
                found      = 1'b1;
                sel_rgn[i] = 1'b1;
                sel_idx    = IDX_W'(i);
                sel_wr     = attr[i].wr_en;
            end
        end
    end

    always_comb begin
        err = !found || (we && !sel_wr);
        rgn = err ? '0 : sel_rgn;
        idx = err ? '0 : sel_idx;
    end

endmodule

// File: rtl/liteic_addr_router.sv
// Registered, runtime-programmable address router: region table, one-deep
// valid/ready output stage and sticky first-error log with saturating count.
module liteic_addr_router
    import liteic_pkg::*;
#(
    parameter  int                    ADDR_WIDTH  = 32,
    parameter  int                    NUM_REGIONS = 4,
    parameter  logic [ADDR_WIDTH-1:0] RST_BASE [NUM_REGIONS] = '{default: '0},
    parameter  logic [ADDR_WIDTH-1:0] RST_SIZE [NUM_REGIONS] = '{default: '0},
    parameter  logic [1:0]            RST_ATTR [NUM_REGIONS] = '{default: 2'b11},
    parameter  int                    ERR_CNT_W   = 16,
    localparam int                    IDX_W       = idx_width(NUM_REGIONS)
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic                   req_we_i,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output logic [ADDR_WIDTH-1:0]  dec_addr_o,
    output logic                   dec_we_o,
    output logic [NUM_REGIONS-1:0] dec_rgn_o,
    output logic [IDX_W-1:0]       dec_idx_o,
    output logic                   dec_err_o,
    input  logic                   cfg_we_i,
    input  logic [IDX_W-1:0]       cfg_idx_i,
    input  logic [1:0]             cfg_field_i,
    input  logic [ADDR_WIDTH-1:0]  cfg_wdata_i,
    output logic                   err_valid_o,
    output logic [ADDR_WIDTH-1:0]  err_addr_o,
    output logic                   err_we_o,
    output logic [ERR_CNT_W-1:0]   err_cnt_o,
    input  logic                   err_clr_i
);

    logic [ADDR_WIDTH-1:0]  base_q [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  size_q [NUM_REGIONS];
    rgn_attr_t              attr_q [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] m_rgn;
    logic [IDX_W-1:0]       m_idx;
    logic                   m_err;
    logic                   accept;
    logic                   cfg_hit;
    logic [ERR_CNT_W-1:0]   cnt_base;
    logic                   valid_base;

    liteic_addr_match #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_REGIONS (NUM_REGIONS)
    ) u_match (
        .base (base_q),
        .size (size_q),
        .attr (attr_q),
        .addr (req_addr_i),
        .we   (req_we_i),
        .rgn  (m_rgn),
        .idx  (m_idx),
        .err  (m_err)
    );

    assign req_ready_o = !dec_valid_o || dec_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign cfg_hit     = cfg_we_i && (32'(cfg_idx_i) < NUM_REGIONS);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= RST_BASE[i];
                size_q[i] <= RST_SIZE[i];
                attr_q[i] <= rgn_attr_t'(RST_ATTR[i]);
            end
        end else if (cfg_hit) begin
            case (cfg_field_e'(cfg_field_i))
                CFG_BASE: base_q[cfg_idx_i] <= cfg_wdata_i;
                CFG_SIZE: size_q[cfg_idx_i] <= cfg_wdata_i;
                CFG_ATTR: attr_q[cfg_idx_i] <= rgn_attr_t'(cfg_wdata_i[1:0]);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            dec_valid_o <= 1'b0;
            dec_addr_o  <= '0;
            dec_we_o    <= 1'b0;
            dec_rgn_o   <= '0;
            dec_idx_o   <= '0;
            dec_err_o   <= 1'b0;
        end else if (accept) begin
            dec_valid_o <= 1'b1;
            dec_addr_o  <= req_addr_i;
            dec_we_o    <= req_we_i;
            dec_rgn_o   <= m_rgn;
            dec_idx_o   <= m_idx;
            dec_err_o   <= m_err;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

    // clear is applied first so a same-cycle error is recorded as the first one
    always_comb begin
        cnt_base   = err_clr_i ? '0 : err_cnt_o;
        valid_base = err_clr_i ? 1'b0 : err_valid_o;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_we_o    <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            err_valid_o <= valid_base;
            err_cnt_o   <= cnt_base;
            if (err_clr_i) begin
                err_addr_o <= '0;
                err_we_o   <= 1'b0;
            end
            if (accept && m_err) begin
                if (cnt_base != '1) begin
                    err_cnt_o <= cnt_base + 1'b1;
                end
                if (!valid_base) begin
                    err_valid_o <= 1'b1;
                    err_addr_o  <= req_addr_i;
                    err_we_o    <= req_we_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_liteic_addr_router.sv
// Self-checking bench for liteic_addr_router: reference model of region table,
// output stage and error log, per-cycle compare plus directed literal checks.
module tb_liteic_addr_router;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b1;
    logic [31:0] dec_addr_o;
    logic        dec_we_o;
    logic [3:0]  dec_rgn_o;
    logic [1:0]  dec_idx_o;
    logic        dec_err_o;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_idx_i = '0;
    logic [1:0]  cfg_field_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic        err_valid_o;
    logic [31:0] err_addr_o;
    logic        err_we_o;
    logic [1:0]  err_cnt_o;
    logic        err_clr_i = 1'b0;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    logic [31:0] got_q[$];

    liteic_addr_router #(
        .ADDR_WIDTH  (32),
        .NUM_REGIONS (4),
        .ERR_CNT_W   (2)
    ) dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .dec_valid_o (dec_valid_o),
        .dec_ready_i (dec_ready_i),
        .dec_addr_o  (dec_addr_o),
        .dec_we_o    (dec_we_o),
        .dec_rgn_o   (dec_rgn_o),
        .dec_idx_o   (dec_idx_o),
        .dec_err_o   (dec_err_o),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_field_i (cfg_field_i),
        .cfg_wdata_i (cfg_wdata_i),
        .err_valid_o (err_valid_o),
        .err_addr_o  (err_addr_o),
        .err_we_o    (err_we_o),
        .err_cnt_o   (err_cnt_o),
        .err_clr_i   (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // reference model state
    longint unsigned t_base [4];
    longint unsigned t_size [4];
    bit              t_en   [4];
    bit              t_wr   [4];
    bit        m_valid = 0, m_we = 0, m_err = 0;
    bit [31:0] m_addr = 0;
    bit [3:0]  m_rgn = 0;
    bit [1:0]  m_idx = 0;
    bit        e_valid = 0, e_we = 0;
    bit [31:0] e_addr = 0;
    int        e_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_decode(input bit [31:0] a, input bit w,
                                output bit [3:0] r, output bit [1:0] ix, output bit e);
        int pick;
        longint unsigned la;
        pick = -1;
        la = 64'(a);
        for (int i = 3; i >= 0; i--)
            if (t_en[i] && la >= t_base[i] && la < t_base[i] + t_size[i]) pick = i;
        r = 4'b0; ix = 2'b0; e = 1'b1;
        if (pick >= 0 && (!w || t_wr[pick])) begin
            r = 4'b1 << pick;
            ix = 2'(pick);
            e = 1'b0;
        end
    endtask

    always @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < 4; i++) begin
                t_base[i] = 0; t_size[i] = 0; t_en[i] = 1; t_wr[i] = 1;
            end
            m_valid = 0; m_addr = 0; m_we = 0; m_rgn = 0; m_idx = 0; m_err = 0;
            e_valid = 0; e_addr = 0; e_we = 0; e_cnt = 0;
        end else begin
            bit acc;
            bit [3:0] r;
            bit [1:0] ix;
            bit e;
            acc = req_valid_i && (!m_valid || dec_ready_i);
            model_decode(req_addr_i, req_we_i, r, ix, e);
            if (err_clr_i) begin
                e_valid = 0; e_addr = 0; e_we = 0; e_cnt = 0;
            end
            if (acc) begin
                m_valid = 1; m_addr = req_addr_i; m_we = req_we_i;
                m_rgn = r; m_idx = ix; m_err = e;
                if (e) begin
                    e_cnt = (e_cnt < 3) ? e_cnt + 1 : 3;
                    if (!e_valid) begin
                        e_valid = 1; e_addr = req_addr_i; e_we = req_we_i;
                    end
                end
            end else if (dec_ready_i) begin
                m_valid = 0;
            end
            if (cfg_we_i && cfg_field_i != 2'd3) begin
                case (cfg_field_i)
                    2'd0: t_base[cfg_idx_i] = 64'(cfg_wdata_i);
                    2'd1: t_size[cfg_idx_i] = 64'(cfg_wdata_i);
                    default: begin
                        t_en[cfg_idx_i] = cfg_wdata_i[0];
                        t_wr[cfg_idx_i] = cfg_wdata_i[1];
                    end
                endcase
            end
        end
    end

    always @(negedge clk_i) begin
        if (started) begin
            chk("req_ready", req_ready_o, !m_valid || dec_ready_i);
            chk("dec_valid", dec_valid_o, m_valid);
            if (m_valid) begin
                chk("dec_addr", dec_addr_o, m_addr);
                chk("dec_we", dec_we_o, m_we);
                chk("dec_rgn", dec_rgn_o, m_rgn);
                chk("dec_idx", dec_idx_o, m_idx);
                chk("dec_err", dec_err_o, m_err);
            end
            chk("err_valid", err_valid_o, e_valid);
            chk("err_cnt", err_cnt_o, 64'(e_cnt));
            if (e_valid) begin
                chk("err_addr", err_addr_o, e_addr);
                chk("err_we", err_we_o, e_we);
            end
            if (dec_valid_o && dec_ready_i) got_q.push_back(dec_addr_o);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [1:0] field, input logic [31:0] data);
        cfg_we_i = 1; cfg_idx_i = idx; cfg_field_i = field; cfg_wdata_i = data;
        tick();
        cfg_we_i = 0;
    endtask

    task automatic send(input logic [31:0] a, input logic w, input logic clr);
        req_valid_i = 1; req_addr_i = a; req_we_i = w; err_clr_i = clr;
        tick();
        req_valid_i = 0; err_clr_i = 0;
    endtask

    task automatic clr_pulse();
        err_clr_i = 1;
        tick();
        err_clr_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 arstn_i = 0;
        started = 1;
        repeat (3) @(posedge clk_i);
        #1 arstn_i = 1;
        chk("rst_dec_valid", dec_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_err_cnt", err_cnt_o, 0);
        chk("rst_dec_rgn", dec_rgn_o, 0);

        // empty reset table: everything errors
        send(32'h0000_0040, 0, 0);
        chk("rst_table_err", dec_err_o, 1);
        chk("rst_table_cnt", err_cnt_o, 1);

        // 1: basic decode
        cfg(0, 0, 32'h0000_0000); cfg(0, 1, 32'h0000_1000);
        cfg(1, 0, 32'h0000_1000); cfg(1, 1, 32'h0000_1000);
        send(32'h0000_0FFF, 0, 0);
        chk("t1_rgn0", dec_rgn_o, 4'b0001); chk("t1_idx0", dec_idx_o, 0);
        send(32'h0000_1000, 0, 0);
        chk("t1_rgn1", dec_rgn_o, 4'b0010); chk("t1_idx1", dec_idx_o, 1);
        send(32'h0000_2000, 0, 0);
        chk("t1_err", dec_err_o, 1); chk("t1_err_rgn", dec_rgn_o, 0);
        chk("t1_sticky_addr", err_addr_o, 32'h0000_0040);

        // 2: overlap, lowest index wins
        cfg(2, 0, 32'h0000_0800); cfg(2, 1, 32'h0000_1000);
        send(32'h0000_0900, 0, 0);
        chk("t2_rgn", dec_rgn_o, 4'b0001);

        // 3: write protect
        clr_pulse();
        chk("t3_clr_cnt", err_cnt_o, 0);
        cfg(1, 2, 32'h0000_0001);
        send(32'h0000_1004, 1, 0);
        chk("t3_err", dec_err_o, 1);
        chk("t3_err_addr", err_addr_o, 32'h0000_1004);
        chk("t3_err_we", err_we_o, 1);
        send(32'h0000_1004, 0, 0);
        chk("t3_rd_rgn", dec_rgn_o, 4'b0010); chk("t3_rd_err", dec_err_o, 0);

        // 4: back-pressure and streaming
        tick();
        got_q.delete();
        dec_ready_i = 0;
        req_valid_i = 1; req_addr_i = 32'h0000_0100; req_we_i = 0;
        tick();
        req_addr_i = 32'h0000_1100;
        for (int i = 0; i < 3; i++) begin
            chk("t4_ready_low", req_ready_o, 0);
            chk("t4_hold_addr", dec_addr_o, 32'h0000_0100);
            chk("t4_hold_rgn", dec_rgn_o, 4'b0001);
            tick();
        end
        dec_ready_i = 1;
        tick();
        req_addr_i = 32'h0000_0200;
        tick();
        req_addr_i = 32'h0000_1200;
        tick();
        req_valid_i = 0;
        tick();
        tick();
        chk("t4_xfer_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("t4_xfer0", got_q[0], 32'h0000_0100);
            chk("t4_xfer1", got_q[1], 32'h0000_1100);
            chk("t4_xfer2", got_q[2], 32'h0000_0200);
            chk("t4_xfer3", got_q[3], 32'h0000_1200);
        end

        // 5: top of map, reserved field, same-cycle config
        cfg(3, 0, 32'hFFFF_F000); cfg(3, 1, 32'h0000_1000);
        send(32'hFFFF_FFFF, 0, 0);
        chk("t5_top_rgn", dec_rgn_o, 4'b1000); chk("t5_top_idx", dec_idx_o, 3);
        cfg(0, 3, 32'h0000_0000);
        send(32'h0000_0FFF, 0, 0);
        chk("t5_rsvd_rgn", dec_rgn_o, 4'b0001);
        cfg_we_i = 1; cfg_idx_i = 0; cfg_field_i = 1; cfg_wdata_i = 32'h0;
        send(32'h0000_0FFF, 0, 0);
        cfg_we_i = 0;
        chk("t5_old_table", dec_rgn_o, 4'b0001);
        send(32'h0000_0FFF, 0, 0);
        chk("t5_new_table", dec_rgn_o, 4'b0100); chk("t5_new_idx", dec_idx_o, 2);

        // 6: saturation and clear-with-error
        clr_pulse();
        for (int i = 0; i < 5; i++) send(32'h0000_3000 + 32'(i), 0, 0);
        chk("t6_sat_cnt", err_cnt_o, 3);
        chk("t6_first_addr", err_addr_o, 32'h0000_3000);
        send(32'h0000_4000, 0, 1);
        chk("t6_clr_cnt", err_cnt_o, 1);
        chk("t6_clr_valid", err_valid_o, 1);
        chk("t6_clr_addr", err_addr_o, 32'h0000_4000);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
